uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  UART receiver (8N1, LSB first) for the MIPS board's uart_rxd pin; the
//  receiving end of the serial link that host/bench frames drive.
//  Oversamples the line, validates start/stop bits, and queues bytes in a
//  small FIFO with a valid/ready pop interface read by the UART MMIO bridge.
// PARAMETERS
//  CLK_FREQ    25_000_000  clk_in frequency, Hz
//  BAUD        115_200     bit rate; DIV = CLK_FREQ/BAUD (integer, >= 8)
//  DEPTH_LOG2  2           FIFO depth = 2**DEPTH_LOG2 entries
// PORTS
//  clk_in      in   1             system clock
//  sys_rstn    in   1             asynchronous reset, active-low
//  uart_rxd    in   1             serial input, idle high, asynchronous
//  rx_data     out  8             FIFO head byte (valid when rx_valid)
//  rx_valid    out  1             FIFO non-empty
//  rx_ready    in   1             consumer pops head when rx_valid & rx_ready
//  rx_count    out  DEPTH_LOG2+1  bytes currently queued
//  frame_err   out  1             1-cycle pulse: bad stop (or parity) bit
//  overrun     out  1             1-cycle pulse: byte dropped, FIFO full
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, rx_count=0, frame_err=0, overrun=0;
//    synchroniser flops=1; FSM=IDLE; FIFO pointers cleared. Reset mid-frame
//    discards the partial byte; after release, reception resumes only on a
//    fresh high->low edge.
//  - uart_rxd passes a 2-flop synchroniser; rxs = synchronised value.
//  - Bit counter cnt counts 0..DIV-1; data index idx 0..7.
//  - FSM IDLE: on rxs falling edge (prev 1, now 0) -> START, cnt=0.
//  - START: at cnt=DIV/2-1 sample rxs; 0 -> DATA (cnt=0, idx=0);
//    1 -> IDLE (glitch rejected, nothing reported).
//  - DATA: at cnt=DIV-1 shift rxs into shreg[idx] (LSB first); after idx=7
//    -> STOP (or PARITY when PARITY_EN).
//  - STOP: at cnt=DIV-1 sample (mid stop bit). 1 -> push shreg; 0 -> drop
//    byte, pulse frame_err. Either way -> IDLE immediately; a held-low line
//    (break) causes no retrigger until it returns high and falls again.
//  - Push latency: rx_valid (if FIFO was empty) rises the cycle after the
//    stop sample, i.e. ~9.5*DIV + 3 clk after the line's falling edge.
//  - FIFO: show-ahead; rx_data = head entry, combinational from RAM/regs.
//    Pop when rx_valid & rx_ready. Push when full & no pop -> byte dropped,
//    overrun pulses, contents unchanged. Push+pop same cycle -> both occur,
//    count unchanged (also when full). Pointers wrap modulo depth;
//    rx_count ranges 0..2**DEPTH_LOG2.
//  - frame_err and overrun never assert in the same cycle as each other
//    (frame_err suppresses the push).
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1; extra PARITY state after DATA
//    samples 9th bit at cnt=DIV-1; stop sampled next bit; byte pushed only
//    if stop=1 AND XOR(data,parity)=0, otherwise frame_err pulses.
//  Undefined: 8N1 only, no PARITY state, stop bit follows bit 7.
// TESTING (CLK_FREQ=16, BAUD=1 -> DIV=16, DEPTH_LOG2=2)
//  1 Hold sys_rstn=0, uart_rxd=1 -> all outputs 0; release, idle 100 clk ->
//    outputs stay 0.
//  2 Send 0x55 then 0xA3, rx_ready=0 -> rx_count=2, rx_data=0x55; pulse
//    rx_ready 1 clk -> rx_data=0xA3, rx_count=1.
//  3 Drive uart_rxd low 4 clk then high -> no byte, no frame_err, FSM IDLE.
//  4 Send 0x3C with stop bit 0 -> frame_err one pulse, rx_count=0; hold low
//    200 clk -> nothing further; release high, send 0x81 -> received 0x81.
//  5 Send 0x01..0x05, rx_ready=0 -> overrun pulses once at 5th stop sample;
//    drain reads 0x01,0x02,0x03,0x04 in order, then rx_valid=0.
//  6 Assert sys_rstn=0 at data bit 4 of 0x77, release, send 0x12 ->
//    only 0x12 queued; with UART_RX_PARITY_EN, 0x12 + parity 1 -> frame_err.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver (8N1, LSB first) feeding a small
// show-ahead FIFO with a valid/ready pop interface.
// Optional build macro UART_RX_PARITY_EN switches the frame to 8E1: an even
// parity bit follows bit 7 and a byte is queued only if parity and stop agree.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk_in,
    input  logic                  sys_rstn,
    input  logic                  uart_rxd,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CW    = $clog2(DIV);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                state;
    logic                  sync1;
    logic                  rxs;
    logic                  rxs_prev;
    logic [CW-1:0]         cnt;
    logic [2:0]            idx;
    logic [7:0]            shreg;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit;
`endif

    logic                  bit_end;
    logic                  stop_tick;
    logic                  stop_ok;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  push_accept;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;

    assign bit_end   = (cnt == CW'(DIV - 1));
    assign stop_tick = (state == S_STOP) && bit_end;
`ifdef UART_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign stop_ok   = rxs && !((^shreg) ^ par_bit);
`else
    assign stop_ok   = rxs;
`endif
    assign push        = stop_tick && stop_ok;
    assign pop         = rx_valid && rx_ready;
    assign full        = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign push_accept = push && (!full || pop);

    assign rx_count = count;
    assign rx_valid = (count != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sync1    <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync1    <= uart_rxd;
            rxs      <= sync1;
            rxs_prev <= rxs;
        end
    end

    // Frame FSM: start validation, data shifting, stop check, frame_err pulse.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    // Edge-triggered so a held-low (break) line cannot retrigger.
                    if (rxs_prev && !rxs) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == CW'(DIV / 2 - 1)) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt        <= '0;
                        shreg[idx] <= rxs;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        par_bit <= rxs;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        frame_err <= !stop_ok;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; contents need no reset since rx_data is gated by rx_valid.
    always_ff @(posedge clk_in) begin
        if (push_accept) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers, occupancy and overrun pulse.
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && full && !pop;
            if (push_accept) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push_accept, pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo (DIV=16, depth 4): a queue-based model of the
// receive FIFO plus directed frames, with literal expectations at key points.
module tb_uart_rx_fifo;

    localparam int unsigned DIV   = 16;
    localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 10;
`else
    localparam int unsigned NBITS = 9;
`endif
    // Stop-sample edge relative to the edge after the start bit is driven.
    localparam int unsigned STOP_LAT = 2 + DIV / 2 + NBITS * DIV;

    logic       clk_in;
    logic       sys_rstn;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk_in    (clk_in),
        .sys_rstn  (sys_rstn),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        logic        ok;
    } frame_ev_t;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned cyc        = 0;
    int unsigned fe_pulses  = 0;
    int unsigned ov_pulses  = 0;
    int unsigned last_start = 0;
    int unsigned rise_cyc   = 0;
    logic        prev_valid = 1'b0;

    logic [7:0]  q[$];
    frame_ev_t   ev[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model and per-cycle compare: FIFO as a queue, frames as scheduled outcomes.
    always @(posedge clk_in) begin
        logic ready_s, rst_s, pop_m, full_m, exp_fe, exp_ov;
        ready_s = rx_ready;
        rst_s   = sys_rstn;
        cyc++;
        #1;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        if (!rst_s) begin
            q.delete();
            ev.delete();
            chk("rst_data", rx_data, 0);
        end else begin
            pop_m  = ready_s && (q.size() > 0);
            full_m = (q.size() == DEPTH);
            if (pop_m) void'(q.pop_front());
            if (ev.size() > 0 && ev[0].cyc == cyc) begin
                if (!ev[0].ok)                exp_fe = 1'b1;
                else if (full_m && !pop_m)    exp_ov = 1'b1;
                else                          q.push_back(ev[0].data);
                void'(ev.pop_front());
            end
        end
        chk("count", rx_count, q.size());
        chk("valid", rx_valid, q.size() > 0);
        chk("frame_err", frame_err, exp_fe);
        chk("overrun", overrun, exp_ov);
        if (q.size() > 0) chk("data", rx_data, q[0]);
        if (frame_err) fe_pulses++;
        if (overrun) ov_pulses++;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    // Drive one frame starting at a negedge; stop_b=0 leaves the line low.
    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_flip);
        frame_ev_t e;
        e.cyc  = cyc + 1 + STOP_LAT;
        e.data = d;
        e.ok   = stop_b && !par_flip;
        ev.push_back(e);
        last_start = cyc;
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            repeat (DIV) @(negedge clk_in);
        end
`ifdef UART_RX_PARITY_EN
        uart_rxd = (^d) ^ par_flip;
        repeat (DIV) @(negedge clk_in);
`endif
        uart_rxd = stop_b;
        repeat (DIV) @(negedge clk_in);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk_in);
        rx_ready = 1'b0;
    endtask

    initial begin
        int unsigned fe_base;
        sys_rstn = 1'b0;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;

        // 1: reset and idle
        repeat (5) @(negedge clk_in);
        chk("rst_count_lit", rx_count, 0);
        chk("rst_valid_lit", rx_valid, 0);
        chk("rst_fe_lit", frame_err, 0);
        sys_rstn = 1'b1;
        repeat (100) @(negedge clk_in);
        chk("idle_valid_lit", rx_valid, 0);

        // 2: two bytes, then a single pop
        send(8'h55, 1'b1, 1'b0);
        chk("latency_lit", rise_cyc - last_start, (NBITS == 9) ? 155 : 171);
        send(8'hA3, 1'b1, 1'b0);
        repeat (4) @(negedge clk_in);
        chk("two_count_lit", rx_count, 2);
        chk("two_head_lit", rx_data, 8'h55);
        pop_one();
        chk("pop_head_lit", rx_data, 8'hA3);
        chk("pop_count_lit", rx_count, 1);
        pop_one();
        chk("drained_lit", rx_valid, 0);

        // 3: short glitch is rejected silently
        fe_base = fe_pulses;
        uart_rxd = 1'b0;
        repeat (4) @(negedge clk_in);
        uart_rxd = 1'b1;
        repeat (40) @(negedge clk_in);
        chk("glitch_valid_lit", rx_valid, 0);
        chk("glitch_fe_lit", fe_pulses - fe_base, 0);

        // 4: bad stop bit, held break, then recovery
        send(8'h3C, 1'b0, 1'b0);
        repeat (200) @(negedge clk_in);
        chk("break_fe_lit", fe_pulses - fe_base, 1);
        chk("break_count_lit", rx_count, 0);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk_in);
        send(8'h81, 1'b1, 1'b0);
        repeat (4) @(negedge clk_in);
        chk("recover_data_lit", rx_data, 8'h81);
        chk("recover_count_lit", rx_count, 1);
        pop_one();

        // 5: overfill by one
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
        repeat (4) @(negedge clk_in);
        chk("overrun_lit", ov_pulses, 1);
        chk("full_count_lit", rx_count, 4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data_lit", rx_data, i);
            pop_one();
        end
        chk("drain_empty_lit", rx_valid, 0);

        // 6: reset during data bit 4 of 0x77, then a fresh frame
        uart_rxd = 1'b0;
        repeat (DIV) @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = ((8'h77 >> i) & 8'h01) != 0;
            repeat (DIV) @(negedge clk_in);
        end
        uart_rxd = 1'b1;
        repeat (DIV / 2) @(negedge clk_in);
        sys_rstn = 1'b0;
        repeat (3) @(negedge clk_in);
        sys_rstn = 1'b1;
        repeat (20) @(negedge clk_in);
        fe_base = fe_pulses;
`ifdef UART_RX_PARITY_EN
        send(8'h12, 1'b1, 1'b1);
        repeat (4) @(negedge clk_in);
        chk("par_fe_lit", fe_pulses - fe_base, 1);
        chk("par_count_lit", rx_count, 0);
`else
        send(8'h12, 1'b1, 1'b0);
        repeat (4) @(negedge clk_in);
        chk("after_rst_count_lit", rx_count, 1);
        chk("after_rst_data_lit", rx_data, 8'h12);
`endif
        repeat (10) @(negedge clk_in);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
